div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle integer divide controller for the EX stage of the five-stage MIPS pipeline. It accepts a DIV/DIVU request from EX, runs a 32-iteration restoring shift-subtract sequence, and holds the pipeline through `stallreq_for_div` while it works. At the end it returns the {remainder, quotient} pair, which EX writes into HI/LO.

## Interface
Parameters:
- none. The datapath is fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high. Returns the block to IDLE and clears every register.
- `div_start`  in  1  EX requests a divide. Held high by EX until `div_ready` is seen.
- `div_signed`  in  1  1 selects DIV (signed), 0 selects DIVU. Sampled together with the operands.
- `div_opdata1`  in  32  dividend (rs).
- `div_opdata2`  in  32  divisor (rt).
- `div_annul`  in  1  cancel the current divide (flush).
- `div_result`  out  64  {remainder[63:32], quotient[31:0]}. HI takes the remainder, LO takes the quotient.
- `div_ready`  out  1  result valid.
- `stallreq_for_div`  out  1  stall request to the stall controller (`Stop`=1).

## Operation
- FSM states: IDLE, DIV_ZERO, DIV_ON, DIV_END. A 6-bit iteration counter `cnt` runs alongside.
- IDLE:
  - If `div_start`=1, `div_annul`=0 and divisor≠0: latch the operands, then go to DIV_ON with `cnt`=0.
  - If the same request arrives with divisor=0: go to DIV_ZERO.
  - Otherwise stay in IDLE.
- Operand latch:
  - If `div_signed`=1, latch the absolute values (two's complement negate when bit31=1), and record `neg_q` = sign1^sign2 and `neg_r` = sign1.
  - If `div_signed`=0, latch the raw values and clear both flags.
  - Input changes after the latch are ignored.
- DIV_ON, one quotient bit per cycle, MSB first:
  - Form R' = {R[31:0], next dividend bit}, with 33-bit R starting at 0.
  - If R' ≥ divisor: R = R' − divisor and the quotient bit is 1.
  - Otherwise R = R' and the quotient bit is 0.
  - `cnt` increments every cycle. After iteration 31 (`cnt`=31 → 32), go to DIV_END.
- Result fix-up on entry to DIV_END:
  - Quotient is negated if `neg_q`.
  - Remainder is negated if `neg_r`.
  - All arithmetic is modulo 2^32. 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- DIV_ZERO: the result is forced to 64'h0, then go to DIV_END.
- DIV_END:
  - `div_ready`=1 and `div_result` is valid.
  - If `div_start`=0, return to IDLE. Otherwise hold DIV_END; the result is held stable.
- `div_annul`=1 in DIV_ZERO or DIV_ON: return to IDLE on the next edge. No `div_ready` is produced and the partial result is discarded.
- `div_annul`=1 in DIV_END: return to IDLE.
- `div_annul`=1 in IDLE: blocks a start on that cycle.
- `stallreq_for_div` is 1 when either of these holds:
  - the state is IDLE and `div_start`=1 and `div_annul`=0 (combinational);
  - the state is DIV_ZERO or DIV_ON.
- `stallreq_for_div` is 0 in DIV_END, so the pipeline advances in the same cycle the result is consumed.
- `div_result` is 0 in every state except DIV_END.

## Timing
- Reset values: state IDLE, `cnt`=0, `div_ready`=0, `div_result`=0, `stallreq_for_div`=0 (unless the combinational IDLE start term holds). Reset takes effect immediately and asynchronously, including mid-divide.
- Cycle numbering: cycle 0 is the first cycle `div_start` is high in IDLE.
- Normal divide:
  - Cycle 0: IDLE.
  - Cycles 1–32: DIV_ON.
  - Cycle 33: DIV_END with `div_ready`=1.
  - Stall is high in cycles 0–32 (33 cycles).
- Divide by zero:
  - Cycle 0: IDLE.
  - Cycle 1: DIV_ZERO.
  - Cycle 2: DIV_END with `div_ready`=1.
  - Stall is high in cycles 0–1.
- Back-to-back divides: EX drops `div_start` for at least the cycle after `div_ready`. A new start is accepted no earlier than one cycle after DIV_END exits.
- Annul at cycle k in DIV_ON: state is IDLE at k+1. Stall at k+1 follows only the IDLE start term.

## Test plan
- DIVU 100 / 7:
  - `div_ready` rises exactly at cycle 33.
  - `div_result`=64'h00000002_0000000E.
  - Stall is high in cycles 0–32 and low at 33.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002): `div_result`=64'hFFFFFFFF_FFFFFFFD (rem −1, quot −3).
- Divide by zero, DIVU 5 / 0:
  - DIV_ZERO at cycle 1 and `div_ready` at cycle 2 with `div_result`=0.
  - Stall drops at cycle 2.
- DIV overflow, 0x80000000 / 0xFFFFFFFF: result 64'h00000000_80000000. Also DIVU 0xFFFFFFFF / 1 gives 64'h00000000_FFFFFFFF.
- Annul:
  - Assert `div_annul` at cycle 10 of a DIVU 1000 / 3. `div_ready` must never assert and stall must be 0 at cycle 11 with `div_start` low.
  - A following DIVU 9 / 3 returns 64'h00000000_00000003 at its cycle 33.
- Async reset:
  - Pulse `rst` between edges at cycle 20 of a divide. All outputs must be 0 before the next edge.
  - After release, a fresh DIVU 10 / 4 gives 64'h00000002_00000002.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle 32-bit restoring divider for the EX stage.
// It accepts a DIV/DIVU request, stalls the pipeline while it iterates,
// and returns {remainder, quotient} for HI/LO.
module div_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_start,
   input  logic        div_signed,
   input  logic [31:0] div_opdata1,
   input  logic [31:0] div_opdata2,
   input  logic        div_annul,
   output logic [63:0] div_result,
   output logic        div_ready,
   output logic        stallreq_for_div
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_ON   = 2'd2,
      DIV_END  = 2'd3
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] dvd;      // dividend, shifted left one bit per iteration
   logic [31:0] dvs;      // divisor magnitude
   logic [31:0] rem;      // partial remainder
   logic [31:0] quot;     // quotient bits collected MSB first
   logic        neg_q;
   logic        neg_r;

   logic [31:0] op1_abs;
   logic [31:0] op2_abs;
   logic [32:0] r_shift;
   logic [32:0] r_diff;
   logic        q_bit;
   logic [31:0] r_next;
   logic [31:0] q_next;
   logic [31:0] q_fin;
   logic [31:0] r_fin;

   // Operand magnitudes and one restoring shift-subtract step
   always_comb begin
      op1_abs = (div_signed && div_opdata1[31]) ? -div_opdata1 : div_opdata1;
      op2_abs = (div_signed && div_opdata2[31]) ? -div_opdata2 : div_opdata2;
      r_shift = {rem, dvd[31]};
      r_diff  = r_shift - {1'b0, dvs};
      // No borrow out of the 33-bit subtract means R' >= divisor
      q_bit   = ~r_diff[32];
      r_next  = q_bit ? r_diff[31:0] : r_shift[31:0];
      q_next  = {quot[30:0], q_bit};
      q_fin   = neg_q ? -q_next : q_next;
      r_fin   = neg_r ? -r_next : r_next;
   end

   // Stall while a request is being accepted or the divide is in progress
   always_comb begin
      stallreq_for_div = ((state == IDLE) && div_start && !div_annul) ||
                         (state == DIV_ZERO) || (state == DIV_ON);
   end

   // Control FSM, datapath registers and registered result/ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         dvd        <= '0;
         dvs        <= '0;
         rem        <= '0;
         quot       <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_result <= '0;
         div_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               div_ready  <= 1'b0;
               div_result <= '0;
               if (div_start && !div_annul) begin
                  if (div_opdata2 == '0) begin
                     state <= DIV_ZERO;
                  end else begin
                     state <= DIV_ON;
                     cnt   <= '0;
                     dvd   <= op1_abs;
                     dvs   <= op2_abs;
                     rem   <= '0;
                     quot  <= '0;
                     neg_q <= div_signed & (div_opdata1[31] ^ div_opdata2[31]);
                     neg_r <= div_signed & div_opdata1[31];
                  end
               end
            end
            DIV_ZERO: begin
               if (div_annul) begin
                  state <= IDLE;
               end else begin
                  div_result <= '0;
                  div_ready  <= 1'b1;
                  state      <= DIV_END;
               end
            end
            DIV_ON: begin
               if (div_annul) begin
                  state <= IDLE;
               end else begin
                  rem  <= r_next;
                  quot <= q_next;
                  dvd  <= {dvd[30:0], 1'b0};
                  cnt  <= cnt + 6'd1;
                  if (cnt == 6'd31) begin
                     div_result <= {r_fin, q_fin};
                     div_ready  <= 1'b1;
                     state      <= DIV_END;
                  end
               end
            end
            DIV_END: begin
               if (div_annul || !div_start) begin
                  state      <= IDLE;
                  div_ready  <= 1'b0;
                  div_result <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer. The driver pushes
// expected results computed with plain 64-bit arithmetic; a monitor pops and
// compares on each rising div_ready.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_start = 1'b0;
   logic        div_signed = 1'b0;
   logic [31:0] div_opdata1 = '0;
   logic [31:0] div_opdata2 = '0;
   logic        div_annul = 1'b0;
   logic [63:0] div_result;
   logic        div_ready;
   logic        stallreq_for_div;

   typedef struct {
      logic [63:0] res;
      int unsigned lat;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned start_cyc = 0;
   logic        prev_ready = 1'b0;

   div_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .div_start        (div_start),
      .div_signed       (div_signed),
      .div_opdata1      (div_opdata1),
      .div_opdata2      (div_opdata2),
      .div_annul        (div_annul),
      .div_result       (div_result),
      .div_ready        (div_ready),
      .stallreq_for_div (stallreq_for_div)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: truncating division in 64-bit arithmetic, results modulo 2^32
   function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                           input logic [31:0] b);
      longint x, y, q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'd0, a});
         y = longint'({32'd0, b});
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   // Monitor: compare result and latency on each rising div_ready
   always @(negedge clk) begin
      if (!rst) begin
         if (div_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready actual=1 required=0 result=%h", div_result);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("result", div_result, e.res);
               chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
            end
         end
         if (!div_ready) chk("result_zero_when_idle", div_result, 64'd0);
      end
      prev_ready <= div_ready;
   end

   task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      bit          seen;
      bit          stall_ok;
      int unsigned k;
      e.res = ref_div(sg, a, b);
      e.lat = (b == 32'd0) ? 2 : 33;
      exp_q.push_back(e);
      @(posedge clk); #1;
      div_signed  = sg;
      div_opdata1 = a;
      div_opdata2 = b;
      div_start   = 1'b1;
      start_cyc   = cyc;
      seen        = 1'b0;
      stall_ok    = 1'b1;
      k           = 0;
      while (!seen && k <= 40) begin
         @(negedge clk);
         if (div_ready) seen = 1'b1;
         if (stallreq_for_div !== (k < e.lat)) stall_ok = 1'b0;
         // Operands change after the latch and must be ignored
         if (k == 1) begin
            div_opdata1 = $urandom;
            div_opdata2 = $urandom;
            div_signed  = 1'($urandom);
         end
         k++;
      end
      chk("ready_within_budget", 64'(seen), 64'd1);
      chk("stall_profile", 64'(stall_ok), 64'd1);
      // start still held: result must stay stable
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_ready", 64'(div_ready), 64'd1);
      chk("hold_result", div_result, e.res);
      chk("hold_stall", 64'(stallreq_for_div), 64'd0);
      @(posedge clk); #1 div_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("release_ready", 64'(div_ready), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("reset_ready", 64'(div_ready), 64'd0);
      chk("reset_result", div_result, 64'd0);
      chk("reset_stall", 64'(stallreq_for_div), 64'd0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;

      do_div(1'b0, 32'd100, 32'd7);
      do_div(1'b1, 32'hFFFFFFF9, 32'd2);
      do_div(1'b0, 32'd5, 32'd0);
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
      do_div(1'b0, 32'hFFFFFFFF, 32'd1);
      do_div(1'b1, 32'd5, 32'd0);
      do_div(1'b1, 32'h7FFFFFFF, 32'h80000000);

      // Annul at cycle 10 of DIVU 1000 / 3: no result may appear
      @(posedge clk); #1;
      div_signed  = 1'b0;
      div_opdata1 = 32'd1000;
      div_opdata2 = 32'd3;
      div_start   = 1'b1;
      repeat (10) @(posedge clk);
      #1 div_annul = 1'b1;
      @(posedge clk); #1;
      div_annul = 1'b0;
      div_start = 1'b0;
      @(negedge clk);
      chk("annul_stall", 64'(stallreq_for_div), 64'd0);
      chk("annul_ready", 64'(div_ready), 64'd0);
      repeat (40) @(negedge clk);
      do_div(1'b0, 32'd9, 32'd3);

      // Asynchronous reset between edges at cycle 20 of a divide
      @(posedge clk); #1;
      div_signed  = 1'b1;
      div_opdata1 = 32'd12345;
      div_opdata2 = 32'd7;
      div_start   = 1'b1;
      repeat (20) @(posedge clk);
      #1 div_start = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("async_rst_ready", 64'(div_ready), 64'd0);
      chk("async_rst_result", div_result, 64'd0);
      chk("async_rst_stall", 64'(stallreq_for_div), 64'd0);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_quiet", 64'(div_ready), 64'd0);
      do_div(1'b0, 32'd10, 32'd4);

      // Randomized divides, including small and zero divisors
      for (int i = 0; i < 30; i++) begin
         logic [31:0] a, b;
         logic        sg;
         a  = $urandom;
         sg = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 16));
            2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            default: b = $urandom;
         endcase
         do_div(sg, a, b);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
